dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory target for the pipelined CPU's load/store port; replaces the zero-latency
//  combinational data memory once the MEM stage gains a stall path.
//  Accepts one request at a time over a valid/ready channel and returns a response after
//  a fixed, parameterised latency. Flags out-of-range and misaligned accesses.
// PARAMETERS
//  DEPTH_WORDS  1024      number of 32-bit words; power of two, >= 4
//  LATENCY      2         cycles from request accept to rsp_valid; legal range 1..15
//  BASE_ADDR    32'h0     byte address of word 0; aligned to 4*DEPTH_WORDS
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst        in   1   reset: synchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept a request this cycle
//  req_we     in   1   1 = store, 0 = load
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, byte lane i = bits [8i+7:8i]
//  req_be     in   4   store byte enables; ignored for loads
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   requester accepts response
//  rsp_rdata  out  32  load data; 0 for stores and errors
//  rsp_err    out  1   access was out of range or misaligned
// BEHAVIOUR
//  - Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter 0.
//    Array contents are NOT cleared by rst.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: req_ready=1. On req_valid: capture the request, go WAIT (or RESP if LATENCY=1),
//      counter = LATENCY-1.
//    WAIT: req_ready=0. Decrement counter; at counter==1 go RESP.
//    RESP: rsp_valid=1, outputs stable until rsp_valid&&rsp_ready, then IDLE.
//  - Latency: request accepted at edge T -> rsp_valid high in cycle following edge T+LATENCY-1,
//    i.e. exactly LATENCY cycles after accept. Throughput: one request per LATENCY+1 cycles
//    minimum, with rsp_ready held high.
//  - Error check at accept: err = (req_addr[1:0]!=0) | (req_addr < BASE_ADDR)
//    | (req_addr >= BASE_ADDR + 4*DEPTH_WORDS).
//  - Store, no err: enabled byte lanes are written at the accept edge. be=4'b0000 is a legal
//    no-op and is still acknowledged.
//  - Load, no err: word index = (req_addr-BASE_ADDR)>>2. Data is read at the accept edge and held
//    in a response register, so a later store cannot alter a pending load response.
//  - Err: no array write; rsp_rdata=0, rsp_err=1.
//  - rsp_err and rsp_rdata are valid only while rsp_valid=1; they are driven to 0 otherwise.
//  - req_valid while req_ready=0: ignored; the requester must hold the request.
//  - rsp_ready while rsp_valid=0: ignored.
//  - rst mid-operation (WAIT/RESP): abort to IDLE and drop the response. A store already
//    accepted stays committed.
//  - Index arithmetic is $clog2(DEPTH_WORDS) bits wide; no wrap-around, because range is checked first.
// STRUCTURE
//  - Shared package mem_pkg:
//    - enum dmem_state_e {IDLE, WAIT, RESP}
//    - struct dmem_req_t {we, addr, wdata, be}
//    - struct dmem_rsp_t {rdata, err}
//    - localparam WORD_BYTES = 4
//  - Sub-module dmem_array: byte-lane-enabled synchronous-write RAM, combinational read;
//    ports clk, we, be, idx, wdata, rdata.
//  - Top: FSM, latency counter, error check, response register.
// TESTING
//  1. Reset, then store addr 0x10 data 0xDEADBEEF be 1111, then load 0x10 (LATENCY=2)
//     -> load rsp_valid exactly 2 cycles after accept; rdata=0xDEADBEEF; err=0.
//  2. Store 0x20 data 0x11223344 be 1111, then store 0x20 data 0xAABBCCDD be 0101, then load
//     -> rdata=0x11BB33DD.
//  3. Load 0x22 (misaligned) and load BASE_ADDR+4*DEPTH_WORDS -> err=1, rdata=0;
//     array unchanged (verify by reading back).
//  4. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rdata stable, req_ready=0;
//     rsp_ready=1 -> IDLE next cycle.
//  5. Pulse rst while in WAIT after a store of 0x55 to 0x30 -> rsp_valid never rises;
//     a later load of 0x30 returns 0x55.
//  6. LATENCY=1 build: back-to-back requests with rsp_ready=1 -> one accept every 2 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder.
// Request/response bundles, FSM states and word geometry.
package mem_pkg;

   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } dmem_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } dmem_rsp_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data RAM with per-byte write enables.
// Writes land on the clock edge; reads are combinational.
module dmem_array
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IW          = $clog2(DEPTH_WORDS)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [WORD_BYTES-1:0] be,
   input  logic [IW-1:0]         idx,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Byte-lane store; contents are never cleared by reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < WORD_BYTES; i++) begin
            if (be[i]) begin
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Latency-parameterised data-memory target for the MEM stage.
// One request in flight; response held until the requester takes it.
module dmem_responder
   import mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int IW = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LIMIT =
      33'(BASE_ADDR) + 33'(WORD_BYTES * DEPTH_WORDS);

   dmem_state_e state;
   logic [3:0]  cnt;
   dmem_rsp_t   hold;

   dmem_req_t   req;
   dmem_rsp_t   rsp_d;
   logic        accept;
   logic        err;
   logic        wr_en;
   logic [IW-1:0] idx;
   logic [31:0] rd;

   assign req = '{
      we:    req_we,
      addr:  req_addr,
      wdata: req_wdata,
      be:    req_be
   };

   assign accept = req_valid & req_ready;

   // Range is checked before indexing, so the index never wraps.
   assign err = (req.addr[1:0] != 2'b00)
              | (req.addr < BASE_ADDR)
              | ({1'b0, req.addr} >= LIMIT);

   assign idx   = IW'((req.addr - BASE_ADDR) >> 2);
   assign wr_en = accept & req.we & ~err;

   assign rsp_d.rdata = (err | req.we) ? 32'h0 : rd;
   assign rsp_d.err   = err;

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .IW         (IW)
   ) u_array (
      .clk  (clk),
      .we   (wr_en),
      .be   (req.be),
      .idx  (idx),
      .wdata(req.wdata),
      .rdata(rd)
   );

   // Request FSM: accept, count out the latency, present and hold the response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         hold      <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  hold      <= rsp_d;
                  cnt       <= 4'(LATENCY - 1);
                  req_ready <= 1'b0;
                  if (LATENCY == 1) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= rsp_d.rdata;
                     rsp_err   <= rsp_d.err;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd1) begin
                  state     <= RESP;
                  cnt       <= '0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= hold.rdata;
                  rsp_err   <= hold.err;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
            end
         endcase
      end
   end

endmodule
